// File: rtl/mac_pkg.sv
// Shared encodings for the memory-access sequencer: request opcodes,
// controller states and data-register source selects.
package mac_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_WDATA   = 4'd2,
        S_ACCESS  = 4'd3,
        S_CAPT    = 4'd4,
        S_IRLOAD  = 4'd5,
        S_DONE    = 4'd6,
        S_ERR     = 4'd7,
        S_RELEASE = 4'd8
    } state_e;

    localparam logic MDR_SRC_BUS = 1'b0;
    localparam logic MDR_SRC_MEM = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit request handshake, register load enables and memory handshake
// of the memory-access sequencer, bundled with controller/requester views.
interface mem_access_ctrl_if;

    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       MARLd;
    logic       MDRLd;
    logic       mdr_sel;
    logic       IRLd;
    logic       mem_en;
    logic       mem_rw;
    logic       mem_moc;

    modport slave (
        input  req_valid, req_op, mem_moc,
        output req_ready, busy, done, err, MARLd, MDRLd, mdr_sel, IRLd,
               mem_en, mem_rw
    );

    modport master (
        output req_valid, req_op, mem_moc,
        input  req_ready, busy, done, err, MARLd, MDRLd, mdr_sel, IRLd,
               mem_en, mem_rw
    );

endinterface

// File: rtl/mac_wait_timer.sv
// Bounded wait counter for the memory handshake; expired flags the last
// allowed wait cycle (count == TIMEOUT_CYC-1).
module mac_wait_timer #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: every variable driven from always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for MAR/MDR/IR loads and the bounded memory handshake; one fetch,
// load or store at a time, all outputs Moore-decoded from the state register.
module mem_access_ctrl
    import mac_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    mem_access_ctrl_if.slave   bus
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   timer_clr;
    logic   timer_en;
    logic   expired;

    // Counter is held at zero outside ACCESS, so it starts from 0 on entry.
    assign timer_clr = (state_q != S_ACCESS);
    assign timer_en  = (state_q == S_ACCESS) && !bus.mem_moc;

    mac_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            op_q    <= OP_FETCH;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.req_op);
                    state_d = (op_e'(bus.req_op) == OP_RSVD) ? S_ERR : S_ADDR;
                end
            end
            S_ADDR:   state_d = (op_q == OP_STORE) ? S_WDATA : S_ACCESS;
            S_WDATA:  state_d = S_ACCESS;
            S_ACCESS: begin
                // Completion is checked first so it wins on the last allowed cycle.
                if (bus.mem_moc) begin
                    state_d = (op_q == OP_STORE) ? S_DONE : S_CAPT;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_CAPT:    state_d = (op_q == OP_FETCH) ? S_IRLOAD : S_DONE;
            S_IRLOAD:  state_d = S_DONE;
            S_DONE,
            S_ERR:     state_d = bus.mem_moc ? S_RELEASE : S_IDLE;
            S_RELEASE: if (!bus.mem_moc) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.MARLd     = 1'b0;
        bus.MDRLd     = 1'b0;
        bus.mdr_sel   = MDR_SRC_BUS;
        bus.IRLd      = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_rw    = 1'b0;
        case (state_q)
            S_IDLE:  bus.req_ready = 1'b1;
            S_ADDR:  bus.MARLd     = 1'b1;
            S_WDATA: begin
                bus.MDRLd   = 1'b1;
                bus.mdr_sel = MDR_SRC_BUS;
            end
            S_ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_rw = (op_q != OP_STORE);
            end
            S_CAPT: begin
                bus.MDRLd   = 1'b1;
                bus.mdr_sel = MDR_SRC_MEM;
                bus.mem_en  = 1'b1;
                bus.mem_rw  = 1'b1;
            end
            S_IRLOAD: bus.IRLd = 1'b1;
            S_DONE:   bus.done = 1'b1;
            S_ERR:    bus.err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: each transaction's expected per-cycle output trace is
// derived from its latency arithmetic and compared cycle by cycle.
module tb_mem_access_ctrl;
    import mac_pkg::*;

    localparam int TO = 15;

    // Bit positions of the observed output vector.
    localparam int RDY = 9, BSY = 8, DN = 7, ER = 6, MAR = 5;
    localparam int MDR = 4, SEL = 3, IR = 2, EN = 1, RW = 0;

    typedef struct {
        int a0;    // first ACCESS cycle
        int n;     // number of ACCESS cycles
        int d;     // done/err cycle
        int e;     // first cycle with mem_en low after success
        int idle;  // cycle in which req_ready returns
        bit ok;
    } geom_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic geom_t geom(input logic [1:0] op, input int w, input int hold);
        geom_t g;
        bit    st;
        st     = (op == OP_STORE);
        g.ok   = (op != OP_RSVD) && (w < TO);
        g.a0   = st ? 3 : 2;
        g.n    = g.ok ? w + 1 : TO;
        g.d    = g.a0 + g.n + ((g.ok && !st) ? 1 : 0) + ((g.ok && op == OP_FETCH) ? 1 : 0);
        g.e    = (op == OP_FETCH) ? g.d - 1 : g.d;
        g.idle = g.d + 1;
        if (g.ok && (g.e + hold + 1 > g.idle)) g.idle = g.e + hold + 1;
        if (op == OP_RSVD) begin
            g.d    = 1;
            g.idle = 2;
        end
        return g;
    endfunction

    function automatic logic [9:0] expect_at(input logic [1:0] op, input int w,
                                             input int hold, input int k);
        geom_t      g;
        logic [9:0] v;
        g = geom(op, w, hold);
        v = '0;
        if (k == 0 || k >= g.idle) begin
            v[RDY] = 1'b1;
        end else begin
            v[BSY] = 1'b1;
            if (op == OP_RSVD) begin
                v[ER] = 1'b1;
            end else begin
                if (k == 1) v[MAR] = 1'b1;
                if (op == OP_STORE && k == 2) v[MDR] = 1'b1;
                if (k >= g.a0 && k < g.a0 + g.n) begin
                    v[EN] = 1'b1;
                    v[RW] = (op != OP_STORE);
                end
                if (g.ok && op != OP_STORE && k == g.a0 + g.n) begin
                    v[MDR] = 1'b1;
                    v[SEL] = 1'b1;
                    v[EN]  = 1'b1;
                    v[RW]  = 1'b1;
                end
                if (g.ok && op == OP_FETCH && k == g.a0 + g.n + 1) v[IR] = 1'b1;
                if (k == g.d) begin
                    if (g.ok) v[DN] = 1'b1;
                    else      v[ER] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    // Memory completes after w wait cycles and keeps moc up hold cycles past mem_en.
    function automatic logic expect_moc(input logic [1:0] op, input int w,
                                        input int hold, input int k);
        geom_t g;
        g = geom(op, w, hold);
        return g.ok && (k >= g.a0 + w) && (k < g.e + hold);
    endfunction

    function automatic logic [9:0] observe();
        return {bus.req_ready, bus.busy, bus.done, bus.err, bus.MARLd, bus.MDRLd,
                bus.mdr_sel, bus.IRLd, bus.mem_en, bus.mem_rw};
    endfunction

    task automatic check(input string tag, input int k, input logic [9:0] obs,
                         input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b (rdy,bsy,dn,er,mar,mdr,sel,ir,en,rw)",
                   tag, k, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] op, input int w,
                           input int hold, input bit noise);
        geom_t g;
        g = geom(op, w, hold);
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.mem_moc   = 1'b0;
        check(tag, 0, observe(), expect_at(op, w, hold, 0));
        for (int k = 1; k <= g.idle; k++) begin
            @(negedge CLK);
            bus.mem_moc   = expect_moc(op, w, hold, k);
            bus.req_valid = (noise && k < g.idle) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_op    = 2'($urandom_range(0, 3));
            check(tag, k, observe(), expect_at(op, w, hold, k));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.mem_moc   = 1'b0;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset", 0, observe(), 10'b1 << RDY);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle", i, observe(), 10'b1 << RDY);
        end

        run_txn("fetch_w0",     OP_FETCH, 0,    0, 1'b0);
        run_txn("store_w3",     OP_STORE, 3,    0, 1'b0);
        run_txn("load_timeout", OP_LOAD,  1000, 0, 1'b0);
        run_txn("load_last",    OP_LOAD,  TO-1, 4, 1'b0);
        run_txn("rsvd",         OP_RSVD,  0,    0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            run_txn("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 4)), 1'b1);
        end

        // Reset while a fetch is waiting in ACCESS.
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FETCH;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        @(negedge CLK);
        check("rst_pre", 2, observe(), expect_at(OP_FETCH, 1000, 0, 2));
        #2 RST_N = 1'b0;
        #1 check("rst_async", 0, observe(), 10'b1 << RDY);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_after", i, observe(), 10'b1 << RDY);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
